// File: rtl/vga_frame_buffer_reader.sv
// Read side of the camera frame buffer: scans a 640x480@60 raster, fetches the 160x120 RGB332 image
// from the DP RAM read port with 4x upscaling and drives the VGA pins through a 2-stage pipeline.
module vga_frame_buffer_reader #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DP_RAM_data_out,
    output logic [16:0] DP_RAM_addr_out,
    output logic        VGA_HSYNC,
    output logic        VGA_VSYNC,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        FRAME_END
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;

    logic        visible_s0;
    logic        hsync_s0;
    logic        vsync_s0;
    logic        frame_end_s0;
    logic [16:0] row_ext;
    logic [16:0] col_ext;
    logic [16:0] addr_s0;

    logic        visible_s1;
    logic        hsync_s1;
    logic        vsync_s1;
    logic        frame_end_s1;

    logic        visible_s2;
    logic        hsync_s2;
    logic        vsync_s2;
    logic        frame_end_s2;

    logic [2:0]  red3;
    logic [2:0]  green3;
    logic [1:0]  blue2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Image row/column are the raster position divided by 4; row*160 is built as row*128 + row*32.
    always_comb begin
        visible_s0   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_s0     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync_s0     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        frame_end_s0 = (h_cnt == H_VIS_LAST) && (v_cnt == V_VIS_LAST);
        row_ext      = {9'd0, v_cnt[9:2]};
        col_ext      = {9'd0, h_cnt[9:2]};
        addr_s0      = (row_ext << 7) + (row_ext << 5) + col_ext;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DP_RAM_addr_out <= '0;
            visible_s1      <= 1'b0;
            hsync_s1        <= 1'b1;
            vsync_s1        <= 1'b1;
            frame_end_s1    <= 1'b0;
        end else begin
            DP_RAM_addr_out <= visible_s0 ? addr_s0 : 17'd0;
            visible_s1      <= visible_s0;
            hsync_s1        <= hsync_s0;
            vsync_s1        <= vsync_s0;
            frame_end_s1    <= frame_end_s0;
        end
    end

    // Second delay stage lines the flags up with the byte the RAM returns for the stage-1 address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            visible_s2   <= 1'b0;
            hsync_s2     <= 1'b1;
            vsync_s2     <= 1'b1;
            frame_end_s2 <= 1'b0;
        end else begin
            visible_s2   <= visible_s1;
            hsync_s2     <= hsync_s1;
            vsync_s2     <= vsync_s1;
            frame_end_s2 <= frame_end_s1;
        end
    end

    always_comb begin
        red3      = DP_RAM_data_out[7:5];
        green3    = DP_RAM_data_out[4:2];
        blue2     = DP_RAM_data_out[1:0];
        VGA_R     = 4'd0;
        VGA_G     = 4'd0;
        VGA_B     = 4'd0;
        if (visible_s2) begin
            VGA_R = {red3, red3[2]};
            VGA_G = {green3, green3[2]};
            VGA_B = {blue2, blue2};
        end
        VGA_HSYNC = hsync_s2;
        VGA_VSYNC = vsync_s2;
        FRAME_END = frame_end_s2;
    end

endmodule

// File: tb/tb_vga_frame_buffer_reader.sv
// Randomised-image bench for vga_frame_buffer_reader: a raster-position reference model predicts every
// output on every clock; vertical timing is shortened so several frames and a mid-frame reset fit the run.
module tb_vga_frame_buffer_reader;

    localparam int HT      = 800;
    localparam int HV      = 640;
    localparam int VV      = 12;
    localparam int VFP     = 3;
    localparam int VS      = 2;
    localparam int VBP     = 3;
    localparam int VT      = VV + VFP + VS + VBP;
    localparam int FRAME   = HT * VT;
    localparam int FE_POS  = (VV - 1) * HT + (HV - 1);
    localparam int RST_POS = 2 * FRAME + 5 * HT + 300;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  ram_q;
    logic [16:0] DP_RAM_addr_out;
    logic        VGA_HSYNC;
    logic        VGA_VSYNC;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        FRAME_END;

    logic [7:0]  mem [0:19199];

    int assertCount = 0;
    int failCount   = 0;
    int k           = 0;

    vga_frame_buffer_reader #(
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .DP_RAM_data_out(ram_q),
        .DP_RAM_addr_out(DP_RAM_addr_out),
        .VGA_HSYNC(VGA_HSYNC),
        .VGA_VSYNC(VGA_VSYNC),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .FRAME_END(FRAME_END)
    );

    always #20 CLK = ~CLK;

    // Synchronous RAM read port: byte appears one clock after the address.
    always @(posedge CLK) ram_q <= mem[DP_RAM_addr_out];

    function automatic int hOf(longint p);
        return int'(p % HT);
    endfunction

    function automatic int vOf(longint p);
        return int'((p / HT) % VT);
    endfunction

    function automatic bit isVisible(longint p);
        return (p >= 0) && (hOf(p) < HV) && (vOf(p) < VV);
    endfunction

    function automatic logic [31:0] modelAddr(longint p);
        if (!isVisible(p)) return 32'd0;
        return 32'((vOf(p) / 4) * 160 + hOf(p) / 4);
    endfunction

    function automatic logic [31:0] modelRgb(longint p);
        int b, r3, g3, b2;
        if (!isVisible(p)) return 32'd0;
        b  = int'(mem[int'(modelAddr(p))]);
        r3 = b / 32;
        g3 = (b / 4) % 8;
        b2 = b % 4;
        return 32'((r3 * 2 + r3 / 4) * 256 + (g3 * 2 + g3 / 4) * 16 + b2 * 5);
    endfunction

    function automatic logic [31:0] modelHs(longint p);
        if (p < 0) return 32'd1;
        return (hOf(p) >= HV + 16 && hOf(p) < HV + 16 + 96) ? 32'd0 : 32'd1;
    endfunction

    function automatic logic [31:0] modelVs(longint p);
        if (p < 0) return 32'd1;
        return (vOf(p) >= VV + VFP && vOf(p) < VV + VFP + VS) ? 32'd0 : 32'd1;
    endfunction

    function automatic logic [31:0] modelFe(longint p);
        if (p < 0) return 32'd0;
        return (hOf(p) == HV - 1 && vOf(p) == VV - 1) ? 32'd1 : 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, k, observed, expected);
        end
    endtask

    // Address reflects the raster position one clock back, pins reflect it two clocks back.
    task automatic checkCycle();
        longint pa = longint'(k) - 1;
        longint po = longint'(k) - 2;
        checkOutput("addr", 32'(DP_RAM_addr_out), modelAddr(pa));
        checkOutput("hsync", 32'(VGA_HSYNC), modelHs(po));
        checkOutput("vsync", 32'(VGA_VSYNC), modelVs(po));
        checkOutput("rgb", 32'({VGA_R, VGA_G, VGA_B}), modelRgb(po));
        checkOutput("frame_end", 32'(FRAME_END), modelFe(po));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_addr"}, 32'(DP_RAM_addr_out), 32'd0);
        checkOutput({tag, "_hsync"}, 32'(VGA_HSYNC), 32'd1);
        checkOutput({tag, "_vsync"}, 32'(VGA_VSYNC), 32'd1);
        checkOutput({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        checkOutput({tag, "_frame_end"}, 32'(FRAME_END), 32'd0);
    endtask

    task automatic applyStimulus(input int cycles, input bit phaseA);
        int hsLow = 0, hsFall = -1, vsLow = 0, vsFall = -1;
        int feCount = 0, feFirst = -1, fePrev = -1;
        for (int n = 0; n < cycles; n++) begin
            @(negedge CLK);
            k++;
            checkCycle();
            if (k - 1 == 3)                checkOutput("addr(3,0)", 32'(DP_RAM_addr_out), 32'd0);
            if (k - 1 == 4)                checkOutput("addr(4,0)", 32'(DP_RAM_addr_out), 32'd1);
            if (k - 1 == 639)              checkOutput("addr(639,0)", 32'(DP_RAM_addr_out), 32'd159);
            if (k - 1 == 4 * HT)           checkOutput("addr(0,4)", 32'(DP_RAM_addr_out), 32'd160);
            if (k - 1 == FE_POS)           checkOutput("addr(639,last)", 32'(DP_RAM_addr_out), 32'(((VV - 1) / 4) * 160 + 159));
            if (k == 2)                    checkOutput("rgb_FF", 32'({VGA_R, VGA_G, VGA_B}), 32'h0FFF);
            if (k == 6)                    checkOutput("rgb_E0", 32'({VGA_R, VGA_G, VGA_B}), 32'h0F00);
            if (k == 10)                   checkOutput("rgb_03", 32'({VGA_R, VGA_G, VGA_B}), 32'h000F);
            if (k >= 2 && k < 2 + HT && !VGA_HSYNC) begin
                if (hsLow == 0) hsFall = k;
                hsLow++;
            end
            if (k >= 2 && k < 2 + FRAME && !VGA_VSYNC) begin
                if (vsLow == 0) vsFall = k;
                vsLow++;
            end
            if (FRAME_END) begin
                if (feCount == 0) feFirst = k;
                else checkOutput("fe_period", 32'(k - fePrev), 32'(FRAME));
                fePrev = k;
                feCount++;
            end
        end
        checkOutput("hsync_width", 32'(hsLow), 32'd96);
        checkOutput("hsync_fall", 32'(hsFall), 32'(HV + 16 + 2));
        checkOutput("vsync_width", 32'(vsLow), 32'(VS * HT));
        checkOutput("vsync_fall", 32'(vsFall), 32'((VV + VFP) * HT + 2));
        checkOutput("fe_first", 32'(feFirst), 32'(FE_POS + 2));
        checkOutput("fe_count", 32'(feCount), phaseA ? 32'd2 : 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hFF;
        mem[1] = 8'hE0;
        mem[2] = 8'h03;

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        k = 0;
        checkResetState("reset");
        checkCycle();
        RST = 1'b0;

        applyStimulus(RST_POS, 1'b1);

        // Counter now sits at (300,5) of the third frame: pulse reset for one clock.
        RST = 1'b1;
        @(negedge CLK);
        k = 0;
        checkResetState("midframe_reset");
        RST = 1'b0;

        applyStimulus(FRAME + 900, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
